// File: rtl/ram_xa_xd_be_if.sv
// Bus bundle for ram_xa_xd_be: write port, read port, clock enable and clear control.
// The master drives requests; the RAM (slave) returns read data, valid and busy.
interface ram_xa_xd_be_if #(
    parameter int CAddrLen = 8,
    parameter int CDataLen = 32
);
    localparam int CBeLen = CDataLen / 8;

    logic                AClkHEn;
    logic [CAddrLen-1:0] AAddrWr;
    logic [CDataLen-1:0] AMosi;
    logic                AWrEn;
    logic [CBeLen-1:0]   AByteEn;
    logic [CAddrLen-1:0] AAddrRd;
    logic                ARdEn;
    logic [CDataLen-1:0] AMiso;
    logic                AMisoVld;
    logic                AClrReq;
    logic                AClrBusy;

    modport master (
        output AClkHEn, AAddrWr, AMosi, AWrEn, AByteEn, AAddrRd, ARdEn, AClrReq,
        input  AMiso, AMisoVld, AClrBusy
    );

    modport slave (
        input  AClkHEn, AAddrWr, AMosi, AWrEn, AByteEn, AAddrRd, ARdEn, AClrReq,
        output AMiso, AMisoVld, AClrBusy
    );
endinterface

// File: rtl/ram_xa_xd_be.sv
// Simple-dual-port RAM with byte enables, 1/2-cycle read latency, read-during-write
// bypass and a sequential clear engine that zeroes one word per enabled cycle.
module ram_xa_xd_be #(
    parameter int CAddrLen    = 8,
    parameter int CDataLen    = 32,
    parameter int CRdLat      = 1,
    parameter int CRdNew      = 1,
    parameter int CClrOnReset = 1
) (
    input  logic           AClkH,
    input  logic           AResetB,
    ram_xa_xd_be_if.slave  bus
);
    localparam int CBeLen = CDataLen / 8;
    localparam int CDepth = 1 << CAddrLen;

    typedef enum logic {SIdle, SClr} state_t;

    logic [CDataLen-1:0] mem_r [CDepth];

    state_t              state_q,   state_d;
    logic [CAddrLen-1:0] clr_cnt_q, clr_cnt_d;
    logic                armed_q,   armed_d;
    logic [CAddrLen-1:0] wr_addr_q, wr_addr_d;
    logic [CDataLen-1:0] wr_data_q, wr_data_d;
    logic                wr_en_q,   wr_en_d;
    logic [CBeLen-1:0]   be_q,      be_d;
    logic [CAddrLen-1:0] rd_addr_q, rd_addr_d;
    logic                rd_en_q,   rd_en_d;
    logic [CDataLen-1:0] miso_q,    miso_d;
    logic                vld_q,     vld_d;

    logic                clr_wr, wr_commit, bypass, mem_we;
    logic [CAddrLen-1:0] mem_waddr;
    logic [CDataLen-1:0] mem_wdata, old_wr, merged, rd_word;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        armed_d   = armed_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = wr_en_q;
        be_d      = be_q;
        rd_addr_d = rd_addr_q;
        rd_en_d   = rd_en_q;
        miso_d    = miso_q;
        vld_d     = vld_q;

        // The clear engine owns the single write port; a user write straddling
        // the start of a clear loses to it.
        clr_wr    = (state_q == SClr);
        wr_commit = wr_en_q & ~clr_wr;
        old_wr    = mem_r[wr_addr_q];
        for (int i = 0; i < CBeLen; i++)
            merged[8*i +: 8] = be_q[i] ? wr_data_q[8*i +: 8] : old_wr[8*i +: 8];

        mem_we    = clr_wr | (wr_commit & (|be_q));
        mem_waddr = clr_wr ? clr_cnt_q : wr_addr_q;
        mem_wdata = clr_wr ? '0 : merged;

        bypass  = (CRdNew != 0) && wr_commit && (rd_addr_q == wr_addr_q);
        rd_word = bypass ? merged : mem_r[rd_addr_q];

        if (bus.AClkHEn) begin
            wr_addr_d = bus.AAddrWr;
            wr_data_d = bus.AMosi;
            wr_en_d   = bus.AWrEn & ~clr_wr;
            be_d      = bus.AByteEn;
            rd_addr_d = bus.AAddrRd;
            rd_en_d   = bus.ARdEn;
            miso_d    = rd_word;
            vld_d     = rd_en_q;
            armed_d   = 1'b0;
            case (state_q)
                SIdle: if (bus.AClrReq || armed_q) begin
                    state_d   = SClr;
                    clr_cnt_d = '0;
                end
                SClr: begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) state_d = SIdle;
                end
                default: state_d = SIdle;
            endcase
        end
    end

    always_ff @(posedge AClkH or negedge AResetB) begin
        if (!AResetB) begin
            state_q   <= SIdle;
            clr_cnt_q <= '0;
            armed_q   <= (CClrOnReset != 0);
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            be_q      <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            miso_q    <= '0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            armed_q   <= armed_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            be_q      <= be_d;
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= rd_en_d;
            miso_q    <= miso_d;
            vld_q     <= vld_d;
        end
    end

    // Array contents are deliberately not reset; the clear engine handles that.
    always_ff @(posedge AClkH) begin
        if (bus.AClkHEn && mem_we) mem_r[mem_waddr] <= mem_wdata;
    end

    assign bus.AMiso    = (CRdLat == 2) ? miso_q : rd_word;
    assign bus.AMisoVld = (CRdLat == 2) ? vld_q  : rd_en_q;
    assign bus.AClrBusy = clr_wr;
endmodule

// File: tb/tb_ram_xa_xd_be.sv
// Scoreboard bench: three RAM variants (lat1/new, lat1/old, lat2/new) share one
// stimulus stream; each read pushes its expected word and due cycle per variant.
module tb_ram_xa_xd_be;
    localparam int AL = 4;
    localparam int DL = 32;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic AClkH = 1'b0;
    logic AResetB = 1'b0;
    logic en = 1'b1, wr_en = 1'b0, rd_en = 1'b0, clr_req = 1'b0;
    logic [AL-1:0] addr_wr = '0, addr_rd = '0;
    logic [3:0] be = '0;
    logic [31:0] mosi = '0;

    logic [2:0] vld, busy;
    logic [2:0][31:0] miso;

    exp_t q [3][$];
    exp_t mon_e;
    int n_pass = 0, n_tot = 0, ecyc = 0, cnt;
    bit en_edge = 1'b0;

    always #5 AClkH = ~AClkH;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ram_xa_xd_be_if #(.CAddrLen(AL), .CDataLen(DL)) bus ();
        assign bus.AClkHEn = en;
        assign bus.AAddrWr = addr_wr;
        assign bus.AMosi   = mosi;
        assign bus.AWrEn   = wr_en;
        assign bus.AByteEn = be;
        assign bus.AAddrRd = addr_rd;
        assign bus.ARdEn   = rd_en;
        assign bus.AClrReq = clr_req;
        assign vld[g]  = bus.AMisoVld;
        assign busy[g] = bus.AClrBusy;
        assign miso[g] = bus.AMiso;
        ram_xa_xd_be #(
            .CAddrLen(AL), .CDataLen(DL),
            .CRdLat(g == 2 ? 2 : 1), .CRdNew(g == 1 ? 0 : 1), .CClrOnReset(1)
        ) dut (
            .AClkH(AClkH), .AResetB(AResetB), .bus(bus)
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge AClkH);
        #1;
    endtask

    // Called right after the edge that sampled the read.
    task automatic exp_rd(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        q[0].push_back('{d0, ecyc});
        q[1].push_back('{d1, ecyc});
        q[2].push_back('{d2, ecyc + 1});
    endtask

    task automatic rd(input logic [AL-1:0] a, input logic [31:0] d0,
                      input logic [31:0] d1, input logic [31:0] d2);
        addr_rd = a; rd_en = 1'b1;
        tick();
        exp_rd(d0, d1, d2);
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [AL-1:0] a, input logic [31:0] d, input logic [3:0] m);
        addr_wr = a; mosi = d; be = m; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic count_clear(input string nm);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0) chk({nm, "_start"}, {29'd0, busy}, 32'h7);
            cnt += $countones(busy);
            // Write to an already-cleared word mid-clear; it must be dropped.
            if (cnt == 30) begin
                addr_wr = 4'd2; mosi = 32'hFFFF_FFFF; be = 4'hF; wr_en = 1'b1;
            end else wr_en = 1'b0;
        end
        chk({nm, "_cycles"}, cnt, 48);
        chk({nm, "_end"}, {29'd0, busy}, 32'h0);
    endtask

    always @(posedge AClkH) begin
        en_edge = en && AResetB;
        if (en_edge) ecyc++;
    end

    always @(negedge AClkH) begin
        if (en_edge) begin
            for (int k = 0; k < 3; k++) begin
                if (vld[k]) begin
                    if (q[k].size() == 0) chk($sformatf("unexpected_vld%0d", k), {31'd0, vld[k]}, 32'h0);
                    else begin
                        mon_e = q[k].pop_front();
                        chk($sformatf("rd_data%0d", k), miso[k], mon_e.d);
                        chk($sformatf("rd_cycle%0d", k), ecyc, mon_e.due);
                    end
                end else if (q[k].size() > 0 && q[k][0].due < ecyc) begin
                    chk($sformatf("missing_vld%0d", k), {31'd0, vld[k]}, 32'h1);
                    void'(q[k].pop_front());
                end
            end
        end
    end

    initial begin
        tick(); tick();
        chk("rst_vld", {29'd0, vld}, 32'h0);
        chk("rst_busy", {29'd0, busy}, 32'h0);
        AResetB = 1'b1;
        count_clear("clr0");

        for (int a = 0; a < 16; a++) rd(a[AL-1:0], 32'h0, 32'h0, 32'h0);

        wr(4'd3, 32'hDEAD_BEEF, 4'b1111);
        wr(4'd3, 32'h1122_3344, 4'b0101);
        rd(4'd3, 32'hDE22_BE44, 32'hDE22_BE44, 32'hDE22_BE44);

        // Read-during-write to the same address.
        addr_wr = 4'd7; mosi = 32'hA5A5_A5A5; be = 4'hF; wr_en = 1'b1;
        addr_rd = 4'd7; rd_en = 1'b1;
        tick();
        exp_rd(32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5);
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        rd(4'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

        wr(4'd1, 32'h0000_0101, 4'hF);
        wr(4'd2, 32'h0000_0202, 4'hF);
        wr(4'd3, 32'h0000_0303, 4'hF);
        rd(4'd1, 32'h101, 32'h101, 32'h101);
        rd(4'd2, 32'h202, 32'h202, 32'h202);
        rd(4'd3, 32'h303, 32'h303, 32'h303);
        repeat (2) tick();

        // Clock-enable toggling around writes and reads.
        addr_wr = 4'd9; mosi = 32'hCAFE_F00D; be = 4'hF; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; en = 1'b0;
        tick(); tick();
        en = 1'b1;
        rd(4'd9, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D);
        en = 1'b0;
        tick();
        en = 1'b1; addr_wr = 4'd9; mosi = 32'h1234_5678; be = 4'b0011; wr_en = 1'b1;
        tick();
        en = 1'b0; wr_en = 1'b0;
        tick();
        en = 1'b1;
        rd(4'd9, 32'hCAFE_5678, 32'hCAFE_5678, 32'hCAFE_5678);
        en = 1'b0;
        tick(); tick();
        en = 1'b1;
        repeat (3) tick();

        // Clear request, write during clear, reset at clear cycle 5.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("clrreq_busy", {29'd0, busy}, 32'h7);
        wr(4'd3, 32'hFFFF_FFFF, 4'hF);
        repeat (3) tick();
        AResetB = 1'b0;
        #1;
        chk("midclr_rst_vld", {29'd0, vld}, 32'h0);
        chk("midclr_rst_busy", {29'd0, busy}, 32'h0);
        tick(); tick();
        chk("rst_hold_busy", {29'd0, busy}, 32'h0);
        AResetB = 1'b1;
        count_clear("clr1");
        rd(4'd3, 32'h0, 32'h0, 32'h0);
        rd(4'd9, 32'h0, 32'h0, 32'h0);
        rd(4'd2, 32'h0, 32'h0, 32'h0);
        repeat (4) tick();

        for (int k = 0; k < 3; k++) chk($sformatf("drain%0d", k), q[k].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
